// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS byte-writable 32-bit registers plus a
// read-only write counter. Optional self-clearing pulse registers and
// per-register write strobes. Everything runs on OPB_Clk.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h010B2300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B23FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_PULSE_MASK = 32'h0,
  parameter              C_FAMILY     = "virtex5",
  // Value the write counter takes in reset; 0 for normal use.
  parameter logic [31:0] C_WRCNT_INIT = 32'h0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Sequential hint and family name carry no behaviour here.
  logic unused_seq_addr;
  localparam bit unused_family = (C_FAMILY != "");
  assign unused_seq_addr = OPB_seqAddr;

  state_t      state;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic [3:0]  lane_en;
  logic [31:0] rdata;
  logic        hit;
  logic        is_reg;
  logic        is_cnt;
  logic        reg_wr;
  logic [31:0] regs [C_NUM_REGS];
  logic [31:0] wr_count;

  // OPB numbers bit 0 as MSB; copying into [31:0] vectors puts DBus[0] on
  // bit 31 and BE[0] on lane 3 (the most significant byte).
  assign addr    = OPB_ABus;
  assign wdata   = OPB_DBus;
  assign lane_en = OPB_BE;

  assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign offset = (addr - C_BASEADDR) >> 2;
  assign is_reg = offset < 32'(C_NUM_REGS);
  assign is_cnt = offset == 32'(C_NUM_REGS);
  assign reg_wr = (state == IDLE) && hit && is_reg && !OPB_RNW;

  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  en);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = en[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  // Reset asserts immediately but releases two clocks after OPB_Rst_n rises.
  // NOTE: state in always_ff is updated with <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Read mux: selected register or the write counter, zero otherwise.
  // NOTE: the default assignment first keeps this purely combinational;
  // without it any unassigned path would infer a latch.
  always_comb begin
    rdata = '0;
    if (is_cnt) rdata = wr_count;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (offset == 32'(k)) rdata = regs[k];
    end
  end

  // Bus handshake: one ack cycle per select, then wait for select to drop.
  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_DBus    <= '0;
    end else begin
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_DBus    <= '0;
      case (state)
        IDLE: begin
          if (hit) begin
            state <= ACK;
            if (is_reg || is_cnt) begin
              Sl_xferAck <= 1'b1;
              if (OPB_RNW) Sl_DBus <= rdata;
            end else begin
              Sl_errAck <= 1'b1;
            end
          end
        end
        ACK:     state <= WAIT;
        WAIT:    if (!OPB_select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register file, write strobes, pulse-mode clearing and write counter.
  // NOTE: the register array is reset explicitly because its contents drive
  // user logic directly; it must never power up with random values.
  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < C_NUM_REGS; k++) regs[k] <= '0;
      wr_count       <= C_WRCNT_INIT;
      user_wr_strobe <= '0;
    end else begin
      user_wr_strobe <= '0;
      if (reg_wr) wr_count <= wr_count + 32'd1;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (reg_wr && (offset == 32'(k))) begin
          regs[k]           <= merge_bytes(regs[k], wdata, lane_en);
          user_wr_strobe[k] <= 1'b1;
        end else if (C_PULSE_MASK[k] && user_wr_strobe[k]) begin
          // Pulse registers hold written data for the strobe cycle only.
          regs[k] <= '0;
        end
      end
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign user_data_out[32*k +: 32] = regs[k];
  end

endmodule
